// File: rtl/membrane_integrator.sv
// Membrane potential integrator: four-state step pipeline (capture, sum, apply) with clamp, spike and refractory.
// Optional MEMBRANE_SPIKE_RESET_EN: a spiking step writes V_REST instead of the clamped sum.
module membrane_integrator #(
  parameter int DT_SHIFT     = 4,
  parameter int V_REST       = -650,
  parameter int V_THRESH     = 0,
  parameter int V_MAX        = 600,
  parameter int V_MIN        = -1000,
  parameter int REFRAC_STEPS = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dt,
  input  logic signed [15:0] I_K,
  input  logic signed [15:0] I_Na,
  input  logic signed [15:0] I_L,
  input  logic signed [15:0] I_ext,
  output logic signed [15:0] V,
  output logic               v_valid,
  output logic               spike,
  output logic               overrun
);

  localparam int RW = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);
  localparam logic signed [15:0] V_REST16  = 16'(V_REST);
  localparam logic signed [15:0] V_MAX16   = 16'(V_MAX);
  localparam logic signed [15:0] V_MIN16   = 16'(V_MIN);
  localparam logic signed [15:0] V_TH16    = 16'(V_THRESH);
  localparam logic signed [18:0] V_MAX19   = 19'(V_MAX);
  localparam logic signed [18:0] V_MIN19   = 19'(V_MIN);
  localparam logic [RW-1:0]      REFRAC_LD = RW'(REFRAC_STEPS);

  typedef enum logic [1:0] {IDLE, CAPTURE, SUM, APPLY} state_t;

  state_t state_q, state_d;

  logic signed [15:0] i_k_q, i_na_q, i_l_q, i_ext_q;
  logic signed [17:0] net_c, net_q, net_sh;
  logic signed [18:0] sum_c;
  logic signed [15:0] v_clamp, v_next;
  logic               spike_c;
  logic [RW-1:0]      refrac_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dt) state_d = CAPTURE;
      CAPTURE: state_d = SUM;
      SUM:     state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // 18 bits hold the worst case of one positive minus three negative full-scale currents.
  always_comb begin
    net_c = {{2{i_ext_q[15]}}, i_ext_q} - {{2{i_k_q[15]}}, i_k_q}
          - {{2{i_na_q[15]}}, i_na_q} - {{2{i_l_q[15]}}, i_l_q};
  end

  always_comb begin
    net_sh  = net_q >>> DT_SHIFT;
    sum_c   = {{3{V[15]}}, V} + {net_sh[17], net_sh};
    v_clamp = sum_c[15:0];
    if (sum_c > V_MAX19)      v_clamp = V_MAX16;
    else if (sum_c < V_MIN19) v_clamp = V_MIN16;
    spike_c = (V < V_TH16) && (v_clamp >= V_TH16) && (refrac_q == '0);
`ifdef MEMBRANE_SPIKE_RESET_EN
    v_next  = spike_c ? V_REST16 : v_clamp;
`else
    v_next  = v_clamp;
`endif
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && dt) begin
      i_k_q   <= I_K;
      i_na_q  <= I_Na;
      i_l_q   <= I_L;
      i_ext_q <= I_ext;
    end
    if (state_q == SUM) net_q <= net_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      V        <= V_REST16;
      v_valid  <= 1'b0;
      spike    <= 1'b0;
      overrun  <= 1'b0;
      refrac_q <= '0;
    end else begin
      state_q <= state_d;
      v_valid <= 1'b0;
      spike   <= 1'b0;
      if (dt && state_q != IDLE) overrun <= 1'b1;
      if (state_q == APPLY) begin
        V       <= v_next;
        v_valid <= 1'b1;
        spike   <= spike_c;
        if (spike_c)              refrac_q <= REFRAC_LD;
        else if (refrac_q != '0)  refrac_q <= refrac_q - RW'(1);
      end
    end
  end

endmodule
